// File: rtl/clkdiv_pkg.sv
// Shared helpers for the modn clock-divider family.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
//
// Contents:
//   CLKDIV_MIN_DIV : smallest divisor the dividers will run with
//   clkdiv_clamp   : raises any divisor below CLKDIV_MIN_DIV to CLKDIV_MIN_DIV
//   clkdiv_half    : high-phase length H(n) in source cycles, rounded up for odd n
package clkdiv_pkg;

  localparam int unsigned CLKDIV_MIN_DIV = 2;

  // Divisors 0 and 1 cannot form a period with a high and a low phase.
  function automatic logic [31:0] clkdiv_clamp(input logic [31:0] n);
    return (n < CLKDIV_MIN_DIV) ? 32'(CLKDIV_MIN_DIV) : n;
  endfunction

  // (n+1)>>1 for odd n, n>>1 for even n. Written as (n>>1)+n[0] so it
  // cannot overflow even for an all-ones divisor.
  function automatic logic [31:0] clkdiv_half(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/clkdiv_neg_retime.sv
// Single falling-edge retime flop for the odd-divisor 50% duty path.
// Latency: half a source cycle (captures d on the falling edge of clk).
// Backpressure: none.
//
// Ports:
//   clk : source clock (flop triggers on its falling edge)
//   rst : asynchronous active-high reset, clears q
//   d   : posedge phase flop to be retimed
//   q   : d delayed by half a source cycle
//
// Kept as its own module so timing constraints and scan handling can
// target the only negedge element in the divider.
module clkdiv_neg_retime (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/modn_clk_div.sv
// Run-time programmable divide-by-N clock generator with terminal-count strobe.
// Latency: clk_out rises one source cycle after enable/reset release (half more for odd N with ODD_50).
// Backpressure: none; en gates counting, divisor changes are deferred to the period wrap.
//
// Ports:
//   clk     : source clock, the only clock
//   rst     : asynchronous active-high reset
//   en      : run enable; low holds the divider idle with clk_out low
//   div_i   : requested divisor, 0 and 1 treated as 2
//   clk_out : divided clock
//   tc      : one-cycle strobe in the last source cycle of each output period
//   div_cur : divisor currently in effect
module modn_clk_div
  import clkdiv_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 7,
  parameter bit ODD_50  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_i,
  output logic             clk_out,
  output logic             tc,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEF_DIV);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] n_d;
  logic [WIDTH-1:0] div_clamped;
  logic [WIDTH-1:0] half_d;
  logic             hi_q;
  logic             hi_d;
  logic             lo_q;
  logic             at_last;

  assign div_clamped = WIDTH'(clkdiv_clamp(32'(div_i)));

  // n_q >= 2 always, so n_q-1 never underflows and cnt_q+1 never wraps.
  assign at_last = (cnt_q == (n_q - ONE));

  // Next-state count and shadow divisor. The divisor is only sampled at the
  // wrap or while idle, which is what keeps divisor changes glitch-free.
  always_comb begin
    cnt_d = cnt_q;
    n_d   = n_q;
    if (!en) begin
      cnt_d = '0;
      n_d   = div_clamped;
    end else if (at_last) begin
      cnt_d = '0;
      n_d   = div_clamped;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // hi_q is computed from the count it will sit beside after the edge, so
  // the phase flop and the counter always agree within a cycle. At the wrap
  // the new divisor applies, but count 0 is below any H >= 1 either way.
  assign half_d = WIDTH'(clkdiv_half(32'(n_d)));
  assign hi_d   = en & (cnt_d < half_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      n_q   <= DEF_N;
      hi_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      n_q   <= n_d;
      hi_q  <= hi_d;
    end
  end

  // The negedge copy of hi_q only exists in the 50% duty build. Without it
  // lo_q mirrors hi_q so the output select below stays a single expression.
  generate
    if (ODD_50) begin : g_odd50
      clkdiv_neg_retime u_neg_retime (
        .clk (clk),
        .rst (rst),
        .d   (hi_q),
        .q   (lo_q)
      );
    end else begin : g_posedge_only
      assign lo_q = hi_q;
    end
  endgenerate

  // Odd N: ANDing with the half-cycle-late copy trims half a source cycle
  // off the leading edge, leaving a high time of exactly N/2 cycles.
  assign clk_out = (ODD_50 && n_q[0]) ? (hi_q & lo_q) : hi_q;
  assign tc      = en & at_last;
  assign div_cur = n_q;

endmodule

// File: tb/tb_modn_clk_div.sv
module tb_modn_clk_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_i;
  logic       clk_out1, tc1, clk_out0, tc0;
  logic [7:0] div_cur1, div_cur0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  modn_clk_div #(.WIDTH(8), .DEF_DIV(7), .ODD_50(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .div_i(div_i),
    .clk_out(clk_out1), .tc(tc1), .div_cur(div_cur1)
  );

  modn_clk_div #(.WIDTH(8), .DEF_DIV(7), .ODD_50(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .div_i(div_i),
    .clk_out(clk_out0), .tc(tc0), .div_cur(div_cur0)
  );

  typedef struct {
    int div;
    int exp_cur;
    int exp_per;
    int exp_hi1;  // high half-cycles per period, 50% duty build
    int exp_hi0;  // high half-cycles per period, posedge-only build
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int clampi(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Input-drive point: just after a falling edge, well away from both edges.
  task automatic to_drive();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_tc(input string nm);
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!tc1 && guard < 600);
    chk(nm, int'(tc1), 1);
  endtask

  // Starts just after a tc cycle; observes one full period up to the next tc.
  task automatic run_period(output int per, output int hi1, output int hi0,
                            output int first_div);
    logic t;
    per = 0; hi1 = 0; hi0 = 0; first_div = 0;
    do begin
      @(posedge clk);
      #1;
      if (per == 0) first_div = int'(div_cur1);
      per++;
      hi1 += int'(clk_out1);
      hi0 += int'(clk_out0);
      t = tc1;
      @(negedge clk);
      #1;
      hi1 += int'(clk_out1);
      hi0 += int'(clk_out0);
    end while (!t && per < 600);
  endtask

  // Behavioural reference: position within the output period and the
  // period length in force, plus the two phase levels.
  int m_pos, m_n;
  bit m_hi, m_lo;

  initial begin
    int per, hi1, hi0, fd, cyc, guard;

    tbl[0] = '{7,   7,   7,   7,   8};
    tbl[1] = '{4,   4,   4,   4,   4};
    tbl[2] = '{0,   2,   2,   2,   2};
    tbl[3] = '{1,   2,   2,   2,   2};
    tbl[4] = '{9,   9,   9,   9,  10};
    tbl[5] = '{3,   3,   3,   3,   4};
    tbl[6] = '{2,   2,   2,   2,   2};
    tbl[7] = '{255, 255, 255, 255, 256};

    // ---- reset and default ----
    rst = 1'b1; en = 1'b1; div_i = 8'd7;
    #1;
    chk("rst_clk_out1", int'(clk_out1), 0);
    chk("rst_clk_out0", int'(clk_out0), 0);
    chk("rst_tc", int'(tc1), 0);
    chk("rst_div_cur", int'(div_cur1), 7);
    to_drive();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_rise_posedge_only", int'(clk_out0), 1);
    chk("rel_odd50_still_low", int'(clk_out1), 0);
    @(negedge clk); #1;
    chk("rel_odd50_half_later", int'(clk_out1), 1);

    // ---- table of steady-state periods ----
    foreach (tbl[i]) begin
      to_drive();
      en = 1'b0; div_i = 8'(tbl[i].div);
      to_drive();
      to_drive();
      chk($sformatf("tbl%0d_div_cur_idle", i), int'(div_cur1), tbl[i].exp_cur);
      en = 1'b1;
      wait_tc($sformatf("tbl%0d_first_tc", i));
      run_period(per, hi1, hi0, fd);
      chk($sformatf("tbl%0d_period", i), per, tbl[i].exp_per);
      chk($sformatf("tbl%0d_hi_odd50", i), hi1, tbl[i].exp_hi1);
      chk($sformatf("tbl%0d_hi_posedge", i), hi0, tbl[i].exp_hi0);
      chk($sformatf("tbl%0d_div_cur", i), fd, tbl[i].exp_cur);
    end

    // ---- glitch-free change 6 -> 3 at count 2 ----
    to_drive();
    en = 1'b0; div_i = 8'd6;
    to_drive();
    en = 1'b1;
    wait_tc("chg_align");
    cyc = 0;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    @(negedge clk); #1;
    div_i = 8'd3;
    guard = 0;
    do begin @(posedge clk); #1; cyc++; guard++; end while (!tc1 && guard < 20);
    chk("chg_old_period", cyc, 6);
    chk("chg_div_cur_before_wrap", int'(div_cur1), 6);
    run_period(per, hi1, hi0, fd);
    chk("chg_div_cur_after_wrap", fd, 3);
    chk("chg_new_period", per, 3);
    chk("chg_hi_posedge", hi0, 4);
    chk("chg_hi_odd50", hi1, 3);

    // ---- enable gating, N=9, drop at count 4 ----
    to_drive();
    en = 1'b0; div_i = 8'd9;
    to_drive();
    en = 1'b1;
    wait_tc("en_align");
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    chk("en_high_before_drop", int'(clk_out1), 1);
    en = 1'b0;
    #1;
    chk("en_tc_low", int'(tc1), 0);
    @(posedge clk); #1;
    chk("en_drop_odd50", int'(clk_out1), 0);
    chk("en_drop_posedge", int'(clk_out0), 0);
    @(negedge clk); #1;
    chk("en_drop_neg_path", int'(clk_out1), 0);
    to_drive();
    en = 1'b1;
    #1;
    cyc = 1;
    @(posedge clk); #1;
    chk("en_restart_rise", int'(clk_out0), 1);
    guard = 0;
    while (!tc1 && guard < 20) begin @(posedge clk); #1; cyc++; guard++; end
    cyc++;
    chk("en_restart_period", cyc, 9);

    // ---- mid-period reset, N=11, at count 5 ----
    to_drive();
    en = 1'b0; div_i = 8'd11;
    to_drive();
    en = 1'b1;
    wait_tc("rst_align");
    repeat (6) begin @(posedge clk); #1; end
    #2;
    chk("mrst_high_before", int'(clk_out0), 1);
    rst = 1'b1;
    #1;
    chk("mrst_clk_out1", int'(clk_out1), 0);
    chk("mrst_clk_out0", int'(clk_out0), 0);
    chk("mrst_tc", int'(tc1), 0);
    to_drive();
    rst = 1'b0;
    #1;
    chk("mrst_div_cur", int'(div_cur1), 7);
    cyc = 1;
    guard = 0;
    do begin @(posedge clk); #1; cyc++; guard++; end while (!tc1 && guard < 20);
    chk("mrst_first_period", cyc, 7);
    run_period(per, hi1, hi0, fd);
    chk("mrst_next_div", fd, 11);
    chk("mrst_next_period", per, 11);

    // ---- randomized run against the reference model ----
    to_drive();
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    m_pos = 0; m_n = 7; m_hi = 1'b0; m_lo = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) < 2) rst = 1'b1;
      en = ($urandom_range(0, 9) != 0);
      div_i = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40))
                                           : 8'($urandom_range(0, 12));
      if (rst) begin
        m_pos = 0; m_n = 7; m_hi = 1'b0; m_lo = 1'b0;
        #1;
        chk("rnd_async_rst_clk_out", int'(clk_out1 | clk_out0), 0);
      end
      @(posedge clk);
      if (!rst) begin
        if (!en) begin
          m_pos = 0; m_n = clampi(int'(div_i)); m_hi = 1'b0;
        end else begin
          if (m_pos == m_n - 1) begin
            m_pos = 0; m_n = clampi(int'(div_i));
          end else begin
            m_pos++;
          end
          m_hi = (m_pos < (m_n + 1) / 2);
        end
      end
      #1;
      chk("rnd_div_cur", int'(div_cur1), m_n);
      chk("rnd_tc", int'(tc1), int'(en && !rst && m_pos == m_n - 1));
      chk("rnd_tc_posedge_build", int'(tc0), int'(en && !rst && m_pos == m_n - 1));
      chk("rnd_clk_out_posedge_build", int'(clk_out0), int'(m_hi));
      chk("rnd_clk_out_odd50_rise", int'(clk_out1),
          int'((m_n % 2 == 1) ? (m_hi && m_lo) : m_hi));
      @(negedge clk);
      m_lo = rst ? 1'b0 : m_hi;
      #1;
      chk("rnd_clk_out_odd50_fall", int'(clk_out1),
          int'((m_n % 2 == 1) ? (m_hi && m_lo) : m_hi));
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
